// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: FSM state encodings, default sync
// marker and the count-byte range helper.
package prog_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // A frame must carry at least one byte and no more than fits in memory.
  function automatic logic count_ok(input logic [7:0] c, input int max_payload);
    return (c != 8'd0) && (int'(c) <= max_payload);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for a frame in progress: counts cycles without an
// accepted byte and flags the cycle on which the count saturates.
module loader_timeout #(
  parameter int TIMEOUT_W = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] MAX_COUNT = '1;

  logic [TIMEOUT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (clr || !enable || kick) begin
      r_count <= '0;
    end else if (r_count != MAX_COUNT) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted on the idle cycle whose edge takes the count to saturation, so
  // the FSM leaves on that same edge; an accepted byte always wins.
  assign expired = enable && !kick && (r_count == MAX_COUNT - 1'b1);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader feeding the instruction RAM write port; releases
// the core only after a frame with a matching XOR checksum has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 7,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] inst_address,
  output logic [7:0]        inst_data,
  output logic              inst_we,
  output logic              cpu_run,
  output logic              load_err,
  output logic [2:0]        state_dbg
);

  localparam int MAX_PAYLOAD = 2 ** ADDR_W;
  localparam int REM_W       = ADDR_W + 1;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_index;
  logic [REM_W-1:0]  r_remaining;
  logic [7:0]        r_xor;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_we;

  logic w_fire;
  logic w_in_frame;
  logic w_expired;
  logic w_is_sync;

  assign in_ready   = 1'b1;
  assign w_fire     = in_valid && in_ready;
  assign w_is_sync  = (in_data == SYNC_BYTE);
  assign w_in_frame = (r_state == ST_COUNT) || (r_state == ST_DATA) ||
                      (r_state == ST_CHECK);

  loader_timeout #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk     (clk),
    .clr     (clr),
    .enable  (w_in_frame),
    .kick    (w_fire),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_remaining <= '0;
      r_xor       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_we        <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low every cycle so it can only ever be a
      // single-cycle pulse per accepted payload byte.
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire && w_is_sync) r_state <= ST_COUNT;
        end
        ST_COUNT: begin
          if (w_fire) begin
            if (count_ok(in_data, MAX_PAYLOAD)) begin
              r_state     <= ST_DATA;
              r_index     <= '0;
              r_xor       <= '0;
              r_remaining <= REM_W'(in_data);
            end else begin
              r_state <= ST_ERROR;
            end
          end else if (w_expired) begin
            r_state <= ST_ERROR;
          end
        end
        ST_DATA: begin
          if (w_fire) begin
            r_we        <= 1'b1;
            r_addr      <= r_index;
            r_data      <= in_data;
            r_xor       <= r_xor ^ in_data;
            r_index     <= r_index + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == REM_W'(1)) r_state <= ST_CHECK;
          end else if (w_expired) begin
            r_state <= ST_ERROR;
          end
        end
        ST_CHECK: begin
          if (w_fire) begin
            r_state <= (in_data == r_xor) ? ST_RUN : ST_ERROR;
          end else if (w_expired) begin
            r_state <= ST_ERROR;
          end
        end
        ST_RUN, ST_ERROR: begin
          if (w_fire && w_is_sync) r_state <= ST_COUNT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Run and error flags are decodes of the registered state, so they change
  // exactly on the edges that move the FSM into or out of RUN / ERROR.
  assign cpu_run      = (r_state == ST_RUN);
  assign load_err     = (r_state == ST_ERROR);
  assign state_dbg    = r_state;
  assign inst_we      = r_we;
  assign inst_address = r_addr;
  assign inst_data    = r_data;

endmodule
